// File: rtl/de2i_150_qsys_nios2_qsys_pkg.sv
// Shared types for the Nios II sequential multiplier: sequencer states, pass selects
// and the operand pair handed to the external 16x16 multiplier cell.
package de2i_150_qsys_nios2_qsys_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        PASS_NONE = 2'd0,
        PASS_1    = 2'd1,
        PASS_2    = 2'd2
    } pass_e;

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } mul_ops_t;

    // Pass 1 yields a_lo*b_lo + a_hi*b_lo<<16; pass 2 adds the b_hi*a_lo<<16 cross term.
    function automatic mul_ops_t pass_operands(input pass_e pass,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        mul_ops_t ops;
        ops = '0;
        case (pass)
            PASS_1: begin
                ops.src1 = a;
                ops.src2 = b;
            end
            PASS_2: begin
                ops.src1 = {b[DATA_W-1:HALF_W], HALF_W'(0)};
                ops.src2 = {HALF_W'(0), a[HALF_W-1:0]};
            end
            default: ops = '0;
        endcase
        return ops;
    endfunction

endpackage

// File: rtl/de2i_150_qsys_nios2_qsys_mul_seq.sv
// Two-pass sequencer around the external 16x16 multiplier cell; accumulates the
// low 32 bits of a*b and hands them out through a valid/ready pair.
module de2i_150_qsys_nios2_qsys_mul_seq
    import de2i_150_qsys_nios2_qsys_pkg::*;
#(
    parameter int unsigned CELL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] A_mul_src1,
    output logic [DATA_W-1:0] A_mul_src2,
    input  logic [DATA_W-1:0] A_mul_cell_result
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_a, r_b, r_acc, r_result;
    logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_result_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    mul_ops_t          r_ops, w_ops_nxt;
    pass_e             w_pass_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_ops    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ops    <= w_ops_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including a pending accept.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
                ST_RUN:  if (r_cnt == CNT_W'(CELL_LATENCY + 1)) w_state_nxt = ST_DONE;
                ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath next values; cell operands are registered one cycle ahead of their pass.
    always_comb begin
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;
        w_pass_nxt   = PASS_NONE;
        if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_a_nxt    = in_src1;
                        w_b_nxt    = in_src2;
                        w_cnt_nxt  = '0;
                        w_pass_nxt = PASS_1;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == '0) w_pass_nxt = PASS_2;
                    if (r_cnt == CNT_W'(CELL_LATENCY)) w_acc_nxt = A_mul_cell_result;
                    if (r_cnt == CNT_W'(CELL_LATENCY + 1))
                        w_result_nxt = r_acc + A_mul_cell_result;
                end
                default: ;
            endcase
        end
        w_ops_nxt = pass_operands(w_pass_nxt, w_a_nxt, w_b_nxt);
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign A_mul_src1 = r_ops.src1;
    assign A_mul_src2 = r_ops.src2;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_qsys_mul_seq.sv
// Scoreboard bench: one sequencer per legal cell latency, each paired with a cell
// model of matching depth, driven by shared directed stimulus.
module tb_de2i_150_qsys_nios2_qsys_mul_seq;

    typedef struct {
        logic [31:0] res;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_src1 = '0;
    logic [31:0] in_src2 = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_result [2];
    logic [31:0] src1 [2];
    logic [31:0] src2 [2];
    logic [31:0] cell_res [2];
    logic [31:0] c1_s1, c2_s1, c2_s2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] prev_v = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    de2i_150_qsys_nios2_qsys_mul_seq #(.CELL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_result(out_result[0]), .A_mul_src1(src1[0]),
        .A_mul_src2(src2[0]), .A_mul_cell_result(cell_res[0]));

    de2i_150_qsys_nios2_qsys_mul_seq #(.CELL_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_result(out_result[1]), .A_mul_src1(src1[1]),
        .A_mul_src2(src2[1]), .A_mul_cell_result(cell_res[1]));

    // Cell: (x_lo*y_lo + (x_hi*y_lo)<<16) mod 2^32, pipelined 1 or 2 deep.
    function automatic logic [31:0] cell_f(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] xl, xh, yl;
        xl = {16'h0, x[15:0]};
        xh = {16'h0, x[31:16]};
        yl = {16'h0, y[15:0]};
        return (xl * yl) + ((xh * yl) << 16);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1_s1 <= '0;
            c2_s1 <= '0;
            c2_s2 <= '0;
        end else begin
            c1_s1 <= cell_f(src1[0], src2[0]);
            c2_s1 <= cell_f(src1[1], src2[1]);
            c2_s2 <= c2_s1;
        end
    end
    assign cell_res[0] = c1_s1;
    assign cell_res[1] = c2_s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each new result against the head of that instance's queue.
    task automatic mon_one(input int idx);
        exp_t e;
        bit   have;
        if (out_valid[idx] && !prev_v[idx]) begin
            have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                chk($sformatf("lat%0d unexpected out_valid", idx + 1), 32'd1, 32'd0);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("lat%0d result", idx + 1), out_result[idx], e.res);
                chk($sformatf("lat%0d latency", idx + 1), 32'(cyc - e.issue), 32'(idx + 3));
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon_one(0);
            mon_one(1);
            prev_v <= out_valid;
        end else begin
            prev_v <= 2'b00;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (in_ready != 2'b11 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle timeout", 32'(in_ready), 32'd3);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit expect_res, input logic [31:0] res);
        exp_t e;
        wait_idle();
        in_src1  = a;
        in_src2  = b;
        in_valid = 1'b1;
        if (expect_res) begin
            e.res   = res;
            e.issue = cyc + 1;
            q0.push_back(e);
            q1.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_src1  = $urandom;
        in_src2  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, " in_ready"}, 32'(in_ready[i]), 32'd1);
            chk({tag, " out_valid"}, 32'(out_valid[i]), 32'd0);
            chk({tag, " out_result"}, out_result[i], 32'd0);
            chk({tag, " src1"}, src1[i], 32'd0);
            chk({tag, " src2"}, src2[i], 32'd0);
        end
    endtask

    initial begin
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        int          n;
        va = '{32'h00010003, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00010000,
               32'h00001234, 32'h00000007, 32'h80000000, 32'h00030000};
        vb = '{32'h00020005, 32'h00010000, 32'hFFFFFFFF, 32'h00010000,
               32'h00000010, 32'h00000009, 32'h00000002, 32'h00000005};
        vr = '{32'h000B000F, 32'hFFFF0000, 32'h00000001, 32'h00000000,
               32'h00012340, 32'h0000003F, 32'h00000000, 32'h000F0000};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) issue(va[i], vb[i], 1'b1, vr[i]);
        drain();

        // Consumer stall: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(32'h00000007, 32'h00000009, 1'b1, 32'h0000003F);
        n = 0;
        while (!out_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", 32'(out_valid[0]), 32'd1);
            chk("stall out_result", out_result[0], 32'h0000003F);
            chk("stall in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", 32'(in_ready), 32'd3);
        chk("release out_valid", 32'(out_valid), 32'd0);
        drain();

        // Flush while pass 2 is on the cell.
        issue(32'h00010003, 32'h00020005, 1'b0, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush in_ready", 32'(in_ready), 32'd3);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(negedge clk);

        // Flush beats a simultaneous request in IDLE.
        in_src1  = 32'h00000002;
        in_src2  = 32'h00000003;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush vs valid in_ready", 32'(in_ready), 32'd3);
        repeat (6) @(negedge clk);
        issue(32'h0000FFFF, 32'h00010000, 1'b1, 32'hFFFF0000);
        drain();

        // Asynchronous reset mid-operation.
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post reset out_valid", 32'(out_valid), 32'd0);
        issue(32'h00010003, 32'h00020005, 1'b1, 32'h000B000F);
        drain();

        chk("queue lat1 empty", 32'(q0.size()), 32'd0);
        chk("queue lat2 empty", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/de2i_150_qsys_nios2_qsys_mul_seq.md
DE2I_150_QSYS_NIOS2_QSYS_MUL_SEQ -- requirements
Module: de2i_150_qsys_nios2_qsys_mul_seq

Purpose: upstream sequencer for the Nios II 16x16 multiplier cell. It issues two operand passes and accumulates a full 32-bit low-word product.

Interface
REQ-001 Parameter CELL_LATENCY, default 1, meaning clocks from the cell's operand inputs to its result output; legal values are 1 and 2 only.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 in_src1  in  32  multiplicand a.
REQ-007 in_src2  in  32  multiplier b.
REQ-008 flush  in  1  synchronous abort of any operation in flight.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 out_result  out  32  low 32 bits of a*b, unsigned (equal to the signed low word).
REQ-012 A_mul_src1  out  32  cell operand 1.
REQ-013 A_mul_src2  out  32  cell operand 2.
REQ-014 A_mul_cell_result  in  32  cell result, defined as (x_lo*y_lo + ((x_hi*y_lo)<<16)) mod 2^32.

Function
REQ-015 The block SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 On a clock edge in IDLE with in_valid=1, the block SHALL:
- capture a and b;
- clear the cycle counter cnt to 0;
- enter RUN.
REQ-018 In RUN with cnt==0, the block SHALL drive pass 1: A_mul_src1=a and A_mul_src2=b.
REQ-019 In RUN with cnt==1, the block SHALL drive pass 2: A_mul_src1={b[31:16],16'h0} and A_mul_src2={16'h0,a[15:0]}.
REQ-020 At all other times, A_mul_src1 and A_mul_src2 SHALL be 0.
REQ-021 In RUN, cnt SHALL increment by 1 on every edge.
REQ-022 On the edge ending the cycle in which cnt==CELL_LATENCY, the block SHALL capture acc=A_mul_cell_result.
REQ-023 On the edge ending the cycle in which cnt==CELL_LATENCY+1, the block SHALL:
- register out_result=(acc+A_mul_cell_result) mod 2^32;
- enter DONE.
REQ-024 out_valid SHALL be 1 only in DONE, CELL_LATENCY+2 clocks after the accept edge (3 clocks for the default).
REQ-025 out_result SHALL stay stable throughout DONE.
REQ-026 In DONE with out_ready=1, the block SHALL return to IDLE on the next edge.
REQ-027 A new request SHALL be accepted no earlier than the edge after the IDLE return, giving one request per CELL_LATENCY+4 clocks.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, and the in-flight result SHALL be discarded.
REQ-029 When flush and in_valid are both 1 in IDLE, flush SHALL win and no request SHALL be accepted.
REQ-030 A change to in_src1 or in_src2 after acceptance SHALL NOT affect the result.
REQ-031 The accumulation SHALL wrap modulo 2^32, with no overflow flag.

Reset
REQ-032 While reset_n=0, the block SHALL be in IDLE with:
- in_ready=1;
- out_valid=0, out_result=0;
- A_mul_src1=0, A_mul_src2=0;
- acc=0, cnt=0.
REQ-033 Reset asserted in the middle of an operation SHALL abandon it, and no out_valid SHALL follow.
REQ-034 The cell SHALL share reset_n, so its pipeline register also clears.

Structure
REQ-035 The state encoding and the pass-select constants SHALL live in the shared package de2i_150_qsys_nios2_qsys_pkg.
REQ-036 The multiplier cell SHALL stay external; the block SHALL have no sub-modules, and the verification bench SHALL pair it with the existing cell.

Verification
REQ-037 a=0x00010003, b=0x00020005 -> out_result=0x000B000F, out_valid 3 clocks after acceptance (CELL_LATENCY=1).
REQ-038 a=0x0000FFFF, b=0x00010000 -> 0xFFFF0000 (only the pass 2 term contributes).
REQ-039 a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001; a=0x00010000, b=0x00010000 -> 0x00000000 (wrap).
REQ-040 out_ready held at 0 for 5 clocks -> out_valid and out_result hold, in_ready=0; release -> IDLE next edge.
REQ-041 flush in RUN at cnt==1 -> no out_valid, IDLE next edge; the following request computes correctly.
REQ-042 reset_n pulsed low mid-RUN, and CELL_LATENCY=2 run -> outputs at reset values; a 2-stage cell model gives correct results with 4-clock latency.
